// File: rtl/iob_cache_be_responder.sv
// IOb subordinate backed by a byte-writable word memory.
// Reads return after RD_LAT cycles; requests may be held off WAIT_CYC cycles.
module iob_cache_be_responder #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 8,
  parameter int RD_LAT     = 2,
  parameter int WAIT_CYC   = 0
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                iob_valid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_ready_o,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o
);

  localparam int NB   = DATA_W / 8;
  localparam int NB_W = $clog2(NB);
  localparam int MEM_D = 2 ** MEM_ADDR_W;
  localparam logic [3:0] WAIT_V = 4'(WAIT_CYC);
  localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

  if (DATA_W < 8 || DATA_W % 8 != 0) begin : g_bad_data_w
    $error("DATA_W must be a nonzero multiple of 8");
  end
  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("RD_LAT must be in 1..15");
  end
  if (WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_bad_wait_cyc
    $error("WAIT_CYC must be in 0..15");
  end
  if (ADDR_W < NB_W + MEM_ADDR_W) begin : g_bad_addr_w
    $error("ADDR_W too small for MEM_ADDR_W");
  end

  typedef enum logic {
    IDLE,
    READ
  } state_t;

  state_t state;
  logic [3:0] wait_cnt;
  logic [3:0] lat_cnt;
  logic [DATA_W-1:0] mem [MEM_D];

  logic [MEM_ADDR_W-1:0] word;
  logic accept;
  logic wr;
  logic unused;

  assign word = iob_addr_i[NB_W+MEM_ADDR_W-1:NB_W];
  assign unused = ^iob_addr_i;
  assign wr = |iob_wstrb_i;

  // Both handshake outputs decode registered state only.
  assign iob_ready_o = (state == IDLE) && (wait_cnt == WAIT_V);
  assign iob_rvalid_o = (state == READ) && (lat_cnt == 4'd0);
  assign accept = iob_valid_i && iob_ready_o;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= IDLE;
      wait_cnt <= 4'd0;
      lat_cnt <= 4'd0;
      iob_rdata_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            wait_cnt <= 4'd0;
            if (!wr) begin
              iob_rdata_o <= mem[word];
              lat_cnt <= LAT_INIT;
              state <= READ;
            end
          end else if (!iob_valid_i) begin
            wait_cnt <= 4'd0;
          end else if (wait_cnt < WAIT_V) begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        READ: begin
          if (lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (accept && wr) begin
      for (int i = 0; i < NB; i++) begin
        if (iob_wstrb_i[i]) begin
          mem[word][i*8 +: 8] <= iob_wdata_i[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: doc/iob_cache_be_responder.md
IOB_CACHE_BE_RESPONDER -- requirements
Module: iob_cache_be_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 24: byte-address width of the IOb subordinate port.
REQ-002 SHALL have parameter DATA_W, default 32: data width; a multiple of 8. NB_W = log2(DATA_W/8).
REQ-003 SHALL have parameter MEM_ADDR_W, default 8: word-address width of the internal memory (2**MEM_ADDR_W words).
REQ-004 SHALL have parameter RD_LAT, default 2: cycles from read acceptance to rvalid; legal range 1..15.
REQ-005 SHALL have parameter WAIT_CYC, default 0: cycles valid must be held before ready is granted; legal range 0..15.
REQ-006 SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-007 clk_i  input  1  clock; all state changes on the rising edge.
REQ-008 arst_n_i  input  1  reset; asynchronous, active-low.
REQ-009 iob_valid_i  input  1  request valid.
REQ-010 iob_addr_i  input  ADDR_W  byte address.
REQ-011 iob_wdata_i  input  DATA_W  write data.
REQ-012 iob_wstrb_i  input  DATA_W/8  byte strobes; nonzero means write, zero means read.
REQ-013 iob_ready_o  output  1  request accepted this cycle when high together with iob_valid_i.
REQ-014 iob_rvalid_o  output  1  read data valid; one-cycle pulse.
REQ-015 iob_rdata_o  output  DATA_W  read data.

Function
REQ-016 SHALL accept a request in a cycle where iob_valid_i=1 and iob_ready_o=1; addr/wdata/wstrb are sampled only in that cycle.
REQ-017 SHALL index memory with word = iob_addr_i[NB_W+MEM_ADDR_W-1:NB_W]; higher address bits are ignored (aliasing); low NB_W bits are ignored.
REQ-018 SHALL implement states IDLE and READ.
REQ-019 IDLE: wait_cnt (4 bits) increments each cycle iob_valid_i=1 while wait_cnt<WAIT_CYC; clears to 0 when iob_valid_i=0 or on acceptance.
REQ-020 iob_ready_o SHALL equal (state==IDLE && wait_cnt==WAIT_CYC), registered-state derived with no combinational path from inputs.
REQ-021 Write acceptance: on that clock edge, each byte i with iob_wstrb_i[i]=1 is written; other bytes are unchanged; state stays IDLE; no rvalid is generated.
REQ-022 With WAIT_CYC=0, back-to-back writes SHALL be accepted once per cycle.
REQ-023 Read acceptance: capture mem[word] into the rdata register, load lat_cnt=RD_LAT-1, and go to READ.
REQ-024 READ: iob_ready_o=0. If lat_cnt>0, decrement. If lat_cnt==0, drive iob_rvalid_o=1 for exactly that cycle and return to IDLE.
REQ-025 rvalid SHALL therefore be high in cycle t+RD_LAT for acceptance in cycle t. The earliest next acceptance is cycle t+RD_LAT+1 (plus WAIT_CYC).
REQ-026 Only one read SHALL be outstanding; memory cannot change between capture and rvalid because no write is accepted in READ.
REQ-027 iob_rdata_o SHALL hold its last read value between pulses; it is not cleared by writes.
REQ-028 iob_valid_i during READ is ignored (not accepted) and SHALL NOT advance wait_cnt.
REQ-029 Memory contents SHALL NOT be reset; a read of an unwritten word returns undefined data.
REQ-030 Illegal parameters (DATA_W%8!=0, RD_LAT=0, RD_LAT>15 or WAIT_CYC>15) SHALL cause an elaboration-time error.

Reset
REQ-031 While arst_n_i=0, the block SHALL hold state=IDLE, wait_cnt=0, lat_cnt=0, iob_rvalid_o=0 and iob_rdata_o=0.
REQ-032 iob_ready_o SHALL read 1 during and after reset iff WAIT_CYC=0, and 0 otherwise.
REQ-033 Reset asserted mid-read SHALL discard the pending read: no rvalid is issued after release.
REQ-034 Release of arst_n_i SHALL take effect asynchronously; the first acceptance is possible on the first rising edge after release.

Verification
REQ-035 Write/read: with RD_LAT=2 and WAIT_CYC=0, write 0xDEADBEEF to 0x10 with wstrb=0xF, then read 0x10 accepted at cycle t -> ready=0 at t+1..t+2; rvalid=1 only at t+2 with rdata=0xDEADBEEF; ready=1 at t+3.
REQ-036 Partial strobe: word 0x14 holds 0x11223344; write wdata=0x0000AA00 with wstrb=0x2, then read -> 0x1122AA44.
REQ-037 Throughput: WAIT_CYC=0, four writes to 0x0/0x4/0x8/0xC in consecutive cycles -> all accepted in 4 cycles; readback returns each value.
REQ-038 Wait states: WAIT_CYC=3, hold valid -> ready first high in the 4th valid cycle. A second case holds valid for 2 cycles, drops it 1 cycle, then reasserts -> counting restarts from 0.
REQ-039 Aliasing: MEM_ADDR_W=8, write 0x5A5A5A5A to 0x400, read 0x000 -> 0x5A5A5A5A.
REQ-040 Reset mid-read: RD_LAT=4, assert arst_n_i=0 two cycles after read acceptance -> rvalid never pulses and rdata=0; normal operation resumes after release.
